// File: rtl/pulse_stretch.sv
// pulse_stretch: turns a single-cycle trig into a HOLD_CYC-long high level on
// out, followed by a GAP_CYC-long forced low gap. A one-cycle done pulse marks
// the end of each hold window.
// Optional feature macro: PULSE_STRETCH_QUEUE_EN. When it is defined, triggers
// that arrive while busy are counted, up to 3, and replayed back-to-back.
// When it is undefined, those triggers are dropped and pend_cnt reads 0.
// rst_n is a synchronous reset and is ACTIVE HIGH, despite its name.
module pulse_stretch #(
    parameter int unsigned HOLD_CYC = 25_000_000,
    parameter int unsigned GAP_CYC  = 5_000_000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic [1:0] pend_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gap_end;
    logic             pend_nz;

    // The last gap cycle: the point where the FSM either replays, restarts or idles.
    assign gap_end = (state_q == S_GAP) && (cnt_q == CNT_ONE);

`ifdef PULSE_STRETCH_QUEUE_EN
    logic [1:0] pend_q, pend_d;
    logic       enq, deq;

    // A trigger that arrives on the last gap cycle with an empty queue starts
    // the next window directly, so it is not queued. A queued entry is consumed
    // on every gap end that finds the queue non-empty.
    assign enq = trig && (state_q != S_IDLE) && !(gap_end && (pend_q == 2'd0));
    assign deq = gap_end && (pend_q != 2'd0);

    // Pending-event counter: saturates at 3, and is unchanged when enq and deq coincide.
    always_comb begin
        pend_d = pend_q;
        if (enq && !deq) begin
            if (pend_q != 2'd3) pend_d = pend_q + 2'd1;
        end else if (deq && !enq) begin
            pend_d = pend_q - 2'd1;
        end
    end

    // Pending-event register. Reset discards every queued event.
    always_ff @(posedge clk) begin
        if (rst_n) pend_q <= 2'd0;
        else       pend_q <= pend_d;
    end

    assign pend_nz  = (pend_q != 2'd0);
    assign pend_cnt = pend_q;
`else
    assign pend_nz  = 1'b0;
    assign pend_cnt = 2'b00;
`endif

    // Next-state logic. The counter reloads on every window entry and counts
    // down to a terminal value of 1, so it never wraps and is never 0 while
    // the FSM is in HOLD or GAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_ONE) begin
                    if (pend_nz || trig) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state. Registering these values keeps the
    // outputs cycle-aligned with state_q.
    always_comb begin
        out_d  = (state_d == S_HOLD);
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_HOLD) && (state_d == S_GAP);
    end

    // State, counter and output registers. Reset aborts any window with no done pulse.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch with HOLD_CYC=4 and GAP_CYC=2. A phase/position
// reference model pushes the expected outputs for each edge; after that edge
// the bench pops the entry and compares it with the DUT. Directed scenarios
// also check window, done and busy-cycle counts against fixed values.
module tb_pulse_stretch;

    localparam int H = 4;
    localparam int G = 2;
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    typedef struct packed {
        logic       o;
        logic       b;
        logic       d;
        logic [1:0] p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       trig = 1'b0;
    logic       out, busy, done;
    logic [1:0] pend_cnt;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;
    int   m_ph = 0, m_pos = 0, m_pend = 0;
    int   wins, dones, busy_cyc;
    logic prev_out;

    pulse_stretch #(.HOLD_CYC(H), .GAP_CYC(G), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig),
        .out(out), .busy(busy), .done(done), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Phase model: 0 idle, 1 hold, 2 gap. m_pos counts up from 1 within a phase.
    task automatic model_step(input logic t, input logic r);
        exp_t e;
        logic dn;
        dn = 1'b0;
        if (r) begin
            m_ph = 0; m_pos = 0; m_pend = 0;
        end else begin
            case (m_ph)
                0: if (t) begin m_ph = 1; m_pos = 1; end
                1: begin
                    if (t && QEN && m_pend < 3) m_pend++;
                    if (m_pos == H) begin m_ph = 2; m_pos = 1; dn = 1'b1; end
                    else m_pos++;
                end
                default: begin
                    if (m_pos == G) begin
                        if (m_pend > 0) begin
                            m_ph = 1; m_pos = 1; m_pend--;
                            if (t && QEN) m_pend++;
                        end else if (t) begin
                            m_ph = 1; m_pos = 1;
                        end else begin
                            m_ph = 0; m_pos = 0;
                        end
                    end else begin
                        if (t && QEN && m_pend < 3) m_pend++;
                        m_pos++;
                    end
                end
            endcase
        end
        e.o = (m_ph == 1);
        e.b = (m_ph != 0);
        e.d = dn;
        e.p = 2'(m_pend);
        sb.push_back(e);
    endtask

    task automatic do_cycle(input string nm, input int c, input logic t, input logic r);
        exp_t e;
        trig  = t;
        rst_n = r;
        @(posedge clk);
        model_step(t, r);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("%s c%0d out", nm, c), int'(out), int'(e.o));
        chk($sformatf("%s c%0d busy", nm, c), int'(busy), int'(e.b));
        chk($sformatf("%s c%0d done", nm, c), int'(done), int'(e.d));
        chk($sformatf("%s c%0d pend", nm, c), int'(pend_cnt), int'(e.p));
        if (out && !prev_out) wins++;
        prev_out = out;
        if (done) dones++;
        if (busy) busy_cyc++;
    endtask

    task automatic run_test(input string nm, input logic [63:0] mask, input int rst_at,
                            input int ncyc, input int ew, input int ed, input int eb);
        do_cycle({nm, "_rst"}, -2, 1'b0, 1'b1);
        do_cycle({nm, "_rst"}, -1, 1'b1, 1'b1);
        wins = 0; dones = 0; busy_cyc = 0; prev_out = 1'b0;
        for (int c = 0; c < ncyc; c++)
            do_cycle(nm, c, mask[c], (c == rst_at));
        chk({nm, " windows"}, wins, ew);
        chk({nm, " dones"}, dones, ed);
        chk({nm, " busy_cycles"}, busy_cyc, eb);
    endtask

    initial begin
        logic [63:0] m;
        // Single trigger: out in cycles 11-14, done in 15, busy in 11-16.
        m = '0; m[10] = 1'b1;
        run_test("single", m, -1, 30, 1, 1, H + G);
        // Triggers at 10, 12 and 13: two of them are queued when the queue is enabled.
        m = '0; m[10] = 1'b1; m[12] = 1'b1; m[13] = 1'b1;
        run_test("queue3", m, -1, 40, QEN ? 3 : 1, QEN ? 3 : 1, QEN ? 3*(H+G) : H+G);
        // A burst during one hold saturates the queue at 3.
        m = '0; for (int i = 10; i <= 14; i++) m[i] = 1'b1;
        run_test("saturate", m, -1, 50, QEN ? 4 : 1, QEN ? 4 : 1, QEN ? 4*(H+G) : H+G);
        // Reset mid-hold with one queued event; the coincident trigger is ignored.
        m = '0; m[10] = 1'b1; m[12] = 1'b1; m[13] = 1'b1;
        run_test("rst_hold", m, 13, 40, 1, 0, 3);
        // A trigger on the last gap cycle restarts hold immediately.
        m = '0; m[10] = 1'b1; m[16] = 1'b1;
        run_test("gap_edge", m, -1, 35, 2, 2, 2*(H+G));
        // Random triggers with occasional resets; the model check only.
        for (int c = 0; c < 300; c++)
            do_cycle("rand", c, ($urandom_range(3) == 0), ($urandom_range(59) == 0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter HOLD_CYC, default 25_000_000: cycles the output is held high per event; legal range >= 1.
REQ-002 Parameter GAP_CYC, default 5_000_000: forced low cycles between consecutive events; legal range >= 1.
REQ-003 Parameter CNT_W, default 25: counter width; must satisfy 2^CNT_W > max(HOLD_CYC, GAP_CYC).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-high reset.
REQ-006 trig  input  1  single-cycle event request; sampled every clk edge.
REQ-007 out  output  1  stretched level drive (LED/buzzer enable), registered.
REQ-008 busy  output  1  high whenever state is not IDLE, registered.
REQ-009 done  output  1  one-cycle pulse marking the end of each hold window, registered.
REQ-010 pend_cnt  output  2  number of queued, unserviced events.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, HOLD and GAP.
REQ-012 IDLE: when trig=1 is sampled at edge t, go to HOLD and load the counter; out=1 from edge t+1.
REQ-013 HOLD: out SHALL be 1 for exactly HOLD_CYC consecutive cycles, then the FSM goes to GAP.
REQ-014 done SHALL be 1 for exactly the first cycle out is 0 after each HOLD, and 0 otherwise.
REQ-015 GAP: out SHALL be 0 for exactly GAP_CYC cycles.
REQ-016 At the end of GAP: if pend_cnt>0, go to HOLD and decrement pend_cnt; otherwise go to IDLE.
REQ-017 When GAP ends directly into HOLD, out SHALL go 1 on the very next cycle, with no IDLE cycle in between.
REQ-018 busy SHALL equal (state != IDLE) and SHALL be cycle-aligned with the state register.
REQ-019 trig=1 while in HOLD or GAP SHALL be handled per REQ-026/REQ-027 and SHALL never extend or restart the current HOLD.
REQ-020 trig=1 on the same cycle GAP ends with pend_cnt>0: the new trig is queued and the old entry is consumed, so pend_cnt is unchanged.
REQ-021 trig=1 on the same cycle GAP ends with pend_cnt=0 SHALL start HOLD immediately, leaving pend_cnt at 0.
REQ-022 The counter SHALL count down and SHALL never wrap; the terminal count is 1, and a count value of 0 is never used in HOLD or GAP.

Reset
REQ-023 With rst_n=1 at a clk edge, the next state SHALL be IDLE, with counter=0, pend_cnt=0, out=0, busy=0 and done=0.
REQ-024 Reset during HOLD or GAP SHALL abort the window immediately, discard all queued events and produce no done pulse.
REQ-025 trig on a cycle where rst_n=1 SHALL be ignored.

Configuration
REQ-026 With macro PULSE_STRETCH_QUEUE_EN defined: trig in HOLD or GAP increments pend_cnt, saturating at 3; further trig at 3 is dropped.
REQ-027 Without PULSE_STRETCH_QUEUE_EN: trig in HOLD or GAP is dropped, pend_cnt is tied to 2'b00 and no queue logic is synthesized.

Verification (HOLD_CYC=4, GAP_CYC=2 unless stated)
REQ-028 Reset, then trig pulse at cycle 10 -> out=1 in cycles 11-14, done=1 in cycle 15, busy=1 in cycles 11-16, busy=0 from cycle 17.
REQ-029 QUEUE_EN: trig at cycles 10, 12 and 13 -> pend_cnt=2 after cycle 13; out high in 11-14, 17-20 and 23-26; pend_cnt=0 after cycle 22.
REQ-030 QUEUE_EN: 5 trig pulses during one HOLD -> pend_cnt saturates at 3; exactly 4 hold windows in total.
REQ-031 No QUEUE_EN: same stimulus as REQ-029 -> exactly one hold window (cycles 11-14); pend_cnt=0 throughout.
REQ-032 rst_n=1 at cycle 13 during HOLD with pend_cnt=1 -> out=0, busy=0 and pend_cnt=0 from cycle 14; no done pulse; no further windows.
REQ-033 Trig on the last GAP cycle with pend_cnt=0 -> HOLD starts next cycle; out low for exactly 2 cycles between windows.
